// File: rtl/apb_requester.sv
// Purpose: APB requester; turns single valid/ready read/write commands into IDLE->SETUP->ACCESS bus transfers.
// Latency: accept at edge N, rsp_valid in the cycle after edge N+2+wait_states; minimum 3 cycles per transfer.
// Backpressure: cmd_ready is high only in IDLE; optional ACCESS timeout via `define APB_REQ_TIMEOUT_EN.
module apb_requester #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              P_clk,
    input  logic              P_rst,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response strobe
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB bus
    output logic [ADDR_W-1:0] P_addr,
    output logic              P_selx,
    output logic              P_enable,
    output logic              P_write,
    output logic [DATA_W-1:0] P_wdata,
    input  logic              P_ready,
    input  logic [DATA_W-1:0] P_rdata,
    input  logic              P_slverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Latched command; drives the APB address/direction/data lines for the
    // whole transfer and keeps them parked in IDLE.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t state;
    state_t state_nxt;
    req_t   req_q;
    logic   accept;
    logic   complete;
    logic   timeout_hit;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // A transfer ends on a ready completer or, when compiled in, on timeout.
    assign complete  = (state == ACCESS) && (P_ready || timeout_hit);

    assign P_write   = req_q.write;
    assign P_addr    = req_q.addr;
    assign P_wdata   = req_q.wdata;

    // Next-state logic: SETUP always lasts one cycle, ACCESS waits for completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered APB strobes derived from the state being entered.
    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            P_selx   <= 1'b0;
            P_enable <= 1'b0;
        end else begin
            P_selx   <= (state_nxt != IDLE);
            P_enable <= (state_nxt == ACCESS);
        end
    end

    // Capture the command on accept; held unchanged until the next accept.
    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    // Response strobe and captured status; data/err hold until the next completion.
    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= complete;
            if (complete) begin
                // A timed-out transfer (P_ready still low) reports error and no data.
                rsp_rdata <= (req_q.write || !P_ready) ? '0 : P_rdata;
                rsp_err   <= P_ready ? P_slverr : 1'b1;
            end
        end
    end

`ifdef APB_REQ_TIMEOUT_EN
    localparam int             TMO_W    = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Count ACCESS cycles with P_ready low; cleared while in SETUP so each
    // transfer starts its ACCESS phase from zero.
    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if ((state == ACCESS) && !P_ready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th waiting ACCESS cycle; P_ready high on the
    // same edge takes precedence through the complete/rsp logic above.
    assign timeout_hit = !P_ready && (tmo_cnt == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
